// File: rtl/leaf_arb.sv
// Leaf request arbiter: merges recirculated (int) and new (trav) leaf requests into a
// two-entry output buffer, favouring int with a bounded starvation count for trav.
module leaf_arb #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned DEPTH      = 2,
   // Width of leaf_info_t: ray_info plus ln_tri {lindex, lnum_left}
   parameter int unsigned DATA_W     = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              int_to_larb_valid,
   input  logic [DATA_W-1:0] int_to_larb_data,
   output logic              int_to_larb_stall,

   input  logic              trav_to_larb_valid,
   input  logic [DATA_W-1:0] trav_to_larb_data,
   output logic              trav_to_larb_stall,

   output logic              larb_to_tcache_valid,
   output logic [DATA_W-1:0] larb_to_tcache_data,
   input  logic              larb_to_tcache_stall,

   output logic [3:0]        larb_starve_cnt
);

   localparam logic [1:0] DepthC    = DEPTH[1:0];
   localparam logic [3:0] StarveMax = STARVE_MAX[3:0];

   logic [1:0]        count_q, count_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [3:0]        starve_q, starve_d;
   logic [DATA_W-1:0] mem_q [2];

   logic              room;
   logic              grant_int, grant_trav;
   logic              push, pop;
   logic [DATA_W-1:0] push_data;

   // Room uses only registered count so downstream stall never reaches upstream stalls.
   always_comb begin
      room       = rst & (count_q < DepthC);
      grant_int  = room & int_to_larb_valid &
                   (~trav_to_larb_valid | (starve_q < StarveMax));
      grant_trav = room & trav_to_larb_valid &
                   (~int_to_larb_valid | (starve_q >= StarveMax));
      push       = grant_int | grant_trav;
      push_data  = grant_trav ? trav_to_larb_data : int_to_larb_data;
      pop        = (count_q != 2'd0) & ~larb_to_tcache_stall;
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      starve_d = starve_q;

      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (grant_trav || !trav_to_larb_valid) begin
         starve_d = 4'd0;
      end else if (grant_int) begin
         starve_d = (starve_q >= StarveMax) ? StarveMax : starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         starve_q <= 4'd0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         starve_q <= starve_d;
      end
   end

   // Storage carries no valid state, so it is left unreset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign int_to_larb_stall    = int_to_larb_valid & ~grant_int;
   assign trav_to_larb_stall   = trav_to_larb_valid & ~grant_trav;
   assign larb_to_tcache_valid = (count_q != 2'd0);
   assign larb_to_tcache_data  = mem_q[rd_ptr_q];
   assign larb_starve_cnt      = starve_q;

endmodule

// File: doc/leaf_arb.md
LEAF_ARB -- requirements
Module: leaf_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive int-side grants allowed while the trav side waits; legal range 1..15.
REQ-002 Parameter DEPTH, default 2 (fixed): output buffer entries.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; state cleared while rst=0.
REQ-005 int_to_larb_valid  input  1  recirculated leaf request from the intersection unit.
REQ-006 int_to_larb_data  input  $bits(leaf_info_t)  ray_info plus ln_tri {lindex, lnum_left}.
REQ-007 int_to_larb_stall  output  1  int side held; transfer occurs when valid & ~stall.
REQ-008 trav_to_larb_valid  input  1  new leaf request from traversal.
REQ-009 trav_to_larb_data  input  $bits(leaf_info_t)  same format as REQ-006.
REQ-010 trav_to_larb_stall  output  1  trav side held.
REQ-011 larb_to_tcache_valid  output  1  granted leaf request available to the triangle-cache requester.
REQ-012 larb_to_tcache_data  output  $bits(leaf_info_t)  head-of-buffer leaf_info_t.
REQ-013 larb_to_tcache_stall  input  1  downstream cannot accept this cycle.
REQ-014 larb_starve_cnt  output  4  current consecutive int-grant count; debug only.

Function
REQ-015 Transfers occur only in a cycle where valid=1 and stall=0 on the same port.
REQ-016 Output buffer: DEPTH-entry FIFO; the count is 2 bits (0..2).
REQ-017 Push: the granted request's data is written in the grant cycle and is visible at the output no earlier than the next cycle (1-cycle latency).
REQ-018 Pop: a pop occurs when larb_to_tcache_valid & ~larb_to_tcache_stall.
REQ-019 Output ports:
- larb_to_tcache_valid = (count != 0).
- larb_to_tcache_data = head entry.
REQ-020 Room condition: room = (count < DEPTH), computed from registered count only.
- The downstream stall never combinationally reaches an upstream stall.
REQ-021 Grant rule, when room=1:
- Only one side valid: that side is granted.
- Both valid and starve_cnt < STARVE_MAX: int is granted.
- Both valid and starve_cnt == STARVE_MAX: trav is granted.
REQ-022 Grant rule, when room=0: no grant.
REQ-023 Upstream stalls:
- int_to_larb_stall = int_to_larb_valid & ~grant_int.
- trav_to_larb_stall = trav_to_larb_valid & ~grant_trav.
- Each stall is 0 whenever its own valid is 0.
REQ-024 Starvation counter update, priority order:
- Trav granted, or trav_to_larb_valid=0: starve_cnt <= 0.
- Else int granted while trav valid: starve_cnt <= starve_cnt + 1, saturating at STARVE_MAX.
- Else: hold.
REQ-025 Simultaneous push and pop: count is unchanged and FIFO order is preserved.
- When count=2, no push occurs even if a pop occurs in the same cycle (REQ-020).
REQ-026 At most one grant per cycle.
- Data is forwarded unmodified; no field, including lnum_left and lindex, is altered.
REQ-027 FIFO order: output order equals grant order.
- No entry is dropped or duplicated.
REQ-028 Empty buffer with downstream stall asserted: no effect; count stays 0 and no pop occurs.

Reset
REQ-029 When rst=0, asynchronously:
- count=0, FIFO pointers=0, starve_cnt=0.
- larb_to_tcache_valid=0, larb_starve_cnt=0.
REQ-030 While rst=0, both upstream stalls are 0 whenever their valids are 0.
- No grant occurs.
REQ-031 Reset mid-operation discards all buffered entries.
- First grant is possible in the first rising edge with rst=1.
- Buffer contents need no reset; only valid state does.

Verification
REQ-032 Only int valid, 3 back-to-back requests, downstream never stalls:
- Outputs appear 1 cycle after each request, in order.
- int_to_larb_stall stays 0.
REQ-033 Both sides valid continuously, STARVE_MAX=4, no downstream stall:
- Grant pattern is I,I,I,I,T,I,I,I,I,T...
- larb_starve_cnt sequence is 0,1,2,3,4,0.
REQ-034 Downstream stall held high, int valid:
- Two requests are accepted (count=2); int_to_larb_stall=1 from the third cycle.
- Releasing the stall drains both in order.
- Refill resumes the cycle after count<2.
REQ-035 Count=1 with a simultaneous pop and a trav push:
- Count remains 1.
- Output data switches to the trav entry on the next cycle.
REQ-036 Reset with 2 entries buffered and starve_cnt=3:
- larb_to_tcache_valid drops immediately (asynchronously).
- After release, the first output is the next new request.
REQ-037 Randomized valids and downstream stall with a scoreboard:
- Every accepted request is emitted exactly once, unmodified and in grant order.
- Trav never waits for more than STARVE_MAX consecutive int grants.
